// File: rtl/anim_pkg.sv
// Shared types for the sprite animation sequencer.
// ANIM_SEQ_PINGPONG_EN adds the per-slot direction bit used by PINGPONG mode.
package anim_pkg;

   localparam int ANIM_FRAME_BITS = 3;
   localparam int ANIM_TIME_BITS  = 8;

   typedef enum logic [1:0] {OP_NOP, OP_START, OP_STOP, OP_PAUSE} op_e;
   typedef enum logic [1:0] {MODE_LOOP, MODE_ONCE, MODE_PINGPONG, MODE_RSVD} mode_e;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_FINISHED} state_e;

   typedef struct packed {
      state_e                     state;
      logic [ANIM_FRAME_BITS-1:0] len;
      logic [ANIM_TIME_BITS-1:0]  hold;
      mode_e                      mode;
      logic [ANIM_FRAME_BITS-1:0] frame;
      logic [ANIM_TIME_BITS-1:0]  timer;
`ifdef ANIM_SEQ_PINGPONG_EN
      logic                       dir;   // 1 = counting down
`endif
   } slot_t;

   function automatic slot_t slot_reset();
      slot_t s;
      s      = '0;
      s.len  = ANIM_FRAME_BITS'(1);
      s.hold = ANIM_TIME_BITS'(1);
      return s;
   endfunction

endpackage

// File: rtl/anim_step.sv
// Combinational next-state function for one animation slot.
// PINGPONG reversal exists only with ANIM_SEQ_PINGPONG_EN; otherwise mode 2 runs as LOOP.
module anim_step
   import anim_pkg::*;
(
   input  slot_t slot_i,
   output slot_t slot_o,
   output logic  done_o
);

   logic [ANIM_FRAME_BITS-1:0] last;
   logic                       at_last;

   always_comb begin
      slot_o  = slot_i;
      done_o  = 1'b0;
      last    = slot_i.len - ANIM_FRAME_BITS'(1);
      at_last = (slot_i.frame == last);
      if (slot_i.state == ST_RUN) begin
         if (slot_i.timer < slot_i.hold - ANIM_TIME_BITS'(1)) begin
            slot_o.timer = slot_i.timer + ANIM_TIME_BITS'(1);
         end else begin
            slot_o.timer = '0;
            case (slot_i.mode)
               MODE_ONCE: begin
                  if (at_last) begin
                     slot_o.state = ST_FINISHED;
                     done_o       = 1'b1;
                  end else begin
                     slot_o.frame = slot_i.frame + ANIM_FRAME_BITS'(1);
                  end
               end
`ifdef ANIM_SEQ_PINGPONG_EN
               MODE_PINGPONG: begin
                  if (last == '0) begin
                     slot_o.frame = '0;
                     done_o       = 1'b1;
                  end else if (!slot_i.dir) begin
                     slot_o.frame = slot_i.frame + ANIM_FRAME_BITS'(1);
                     if (slot_o.frame == last) begin
                        slot_o.dir = 1'b1;
                        done_o     = 1'b1;
                     end
                  end else begin
                     slot_o.frame = slot_i.frame - ANIM_FRAME_BITS'(1);
                     if (slot_o.frame == '0) slot_o.dir = 1'b0;
                  end
               end
`endif
               default: begin
                  if (at_last) begin
                     slot_o.frame = '0;
                     done_o       = 1'b1;
                  end else begin
                     slot_o.frame = slot_i.frame + ANIM_FRAME_BITS'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/anim_sequencer.sv
// Per-sprite frame-animation controller: one shared step unit walks all slots after each frame start.
// Build option ANIM_SEQ_PINGPONG_EN enables PINGPONG mode; FRAME_BITS/TIME_BITS must match anim_pkg widths.
module anim_sequencer
   import anim_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int FRAME_BITS  = ANIM_FRAME_BITS,
   parameter int TIME_BITS   = ANIM_TIME_BITS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [9:0]                        shpos,
   input  logic [9:0]                        svpos,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [$clog2(NUM_SPRITES)-1:0]    cmd_id,
   input  logic [1:0]                        cmd_op,
   input  logic [1:0]                        cmd_mode,
   input  logic [FRAME_BITS-1:0]             cmd_len,
   input  logic [TIME_BITS-1:0]              cmd_time,
   output logic [NUM_SPRITES*FRAME_BITS-1:0] frame_idx,
   output logic [NUM_SPRITES-1:0]            active,
   output logic [NUM_SPRITES-1:0]            done
);

   localparam int               ID_W    = $clog2(NUM_SPRITES);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SPRITES - 1);

   slot_t                  slots_q [NUM_SPRITES];
   slot_t                  slots_d [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   pend_q, pend_d;
   logic [ID_W-1:0]        cnt_q, cnt_d;
   logic                   tick_hist_q;
   logic                   tick_now, tick_ev;
   slot_t                  step_in, step_nxt;
   logic                   step_done;

   assign tick_now  = (shpos == 10'd0) && (svpos == 10'd0);
   assign tick_ev   = tick_now && !tick_hist_q;
   assign cmd_ready = !busy_q;
   assign step_in   = slots_q[cnt_q];

   anim_step u_step (
      .slot_i (step_in),
      .slot_o (step_nxt),
      .done_o (step_done)
   );

   always_comb begin
      slots_d = slots_q;
      done_d  = '0;
      busy_d  = busy_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      if (busy_q) begin
         slots_d[cnt_q] = step_nxt;
         done_d[cnt_q]  = step_done;
         if (tick_ev) pend_d = 1'b1;
         // A pending (or coincident) tick chains straight into the next walk.
         if (cnt_q == LAST_ID) begin
            if (pend_q || tick_ev) begin
               cnt_d  = '0;
               pend_d = 1'b0;
            end else begin
               busy_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ID_W'(1);
         end
      end else begin
         if (tick_ev) begin
            busy_d = 1'b1;
            cnt_d  = '0;
         end
         if (cmd_valid && (32'(cmd_id) < NUM_SPRITES)) begin
            case (op_e'(cmd_op))
               OP_START: begin
                  slots_d[cmd_id].state = ST_RUN;
                  slots_d[cmd_id].len   = (cmd_len == '0) ? ANIM_FRAME_BITS'(1) : cmd_len;
                  slots_d[cmd_id].hold  = (cmd_time == '0) ? ANIM_TIME_BITS'(1) : cmd_time;
                  slots_d[cmd_id].mode  = (cmd_mode == MODE_RSVD) ? MODE_LOOP : mode_e'(cmd_mode);
                  slots_d[cmd_id].frame = '0;
                  slots_d[cmd_id].timer = '0;
`ifdef ANIM_SEQ_PINGPONG_EN
                  slots_d[cmd_id].dir   = 1'b0;
`endif
               end
               OP_STOP: begin
                  slots_d[cmd_id].state = ST_IDLE;
                  slots_d[cmd_id].frame = '0;
                  slots_d[cmd_id].timer = '0;
               end
               OP_PAUSE: begin
                  if (slots_q[cmd_id].state == ST_RUN)       slots_d[cmd_id].state = ST_HOLD;
                  else if (slots_q[cmd_id].state == ST_HOLD) slots_d[cmd_id].state = ST_RUN;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_SPRITES; k++) slots_q[k] <= slot_reset();
         done_q      <= '0;
         busy_q      <= 1'b0;
         pend_q      <= 1'b0;
         cnt_q       <= '0;
         tick_hist_q <= 1'b0;
      end else begin
         slots_q     <= slots_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         tick_hist_q <= tick_now;
      end
   end

   for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_out
      assign frame_idx[k*FRAME_BITS +: FRAME_BITS] = slots_q[k].frame;
      assign active[k] = (slots_q[k].state == ST_RUN) || (slots_q[k].state == ST_HOLD);
   end
   assign done = done_q;

endmodule
